// File: rtl/alu_pkg.sv
// Shared ALU control codes, ALU-op encodings and the latency helper for the
// ID/EX control pipeline.
package alu_pkg;

  localparam int unsigned CTRL_W_DEF = 5;
  localparam int unsigned CODE_W     = 5;

  typedef enum logic [CODE_W-1:0] {
    ALU_ADD    = 5'b00000,
    ALU_SUB    = 5'b00001,
    ALU_AND    = 5'b00010,
    ALU_OR     = 5'b00011,
    ALU_XOR    = 5'b00100,
    ALU_SLT    = 5'b00101,
    ALU_SLL    = 5'b00110,
    ALU_SRL    = 5'b00111,
    ALU_SRA    = 5'b01000,
    ALU_SLTU   = 5'b01001,
    ALU_PASSB  = 5'b01010,
    ALU_MUL    = 5'b10000,
    ALU_MULH   = 5'b10001,
    ALU_MULHSU = 5'b10010,
    ALU_MULHU  = 5'b10011,
    ALU_DIV    = 5'b10100,
    ALU_DIVU   = 5'b10101,
    ALU_REM    = 5'b10110,
    ALU_REMU   = 5'b10111
  } alu_ctrl_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RI    = 2'b10;
  localparam logic [1:0] ALUOP_PASSB = 2'b11;

  // EX occupancy in cycles: 100xx are multiplies, 101xx are divide/remainder.
  function automatic int unsigned op_latency(input logic [CODE_W-1:0] ctrl,
                                             input int unsigned mul_lat,
                                             input int unsigned div_lat);
    if (ctrl[4:2] == 3'b100) return mul_lat;
    if (ctrl[4:2] == 3'b101) return div_lat;
    return 1;
  endfunction

endpackage

// File: rtl/alu_ctrl_pipe_decode.sv
// Combinational decode of ALU-op and funct fields into an ALU control code.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [1:0]        alu_op,
  input  logic [2:0]        funct3,
  input  logic              funct7_5,
  input  logic              funct7_0,
  input  logic              is_rtype,
  output logic [CODE_W-1:0] ctrl,
  output logic              illegal
);

  always_comb begin
    ctrl    = ALU_ADD;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_ADD:   ctrl = ALU_ADD;
      ALUOP_SUB:   ctrl = ALU_SUB;
      ALUOP_PASSB: ctrl = ALU_PASSB;
      ALUOP_RI: begin
        if (is_rtype && funct7_0) begin
          // M-extension: funct3 selects the op directly within the 10xxx block
          if (ENABLE_M) ctrl = {2'b10, funct3};
          else          illegal = 1'b1;
        end else begin
          case (funct3)
            3'b000:  ctrl = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  ctrl = ALU_SLL;
            3'b010:  ctrl = ALU_SLT;
            3'b011:  ctrl = ALU_SLTU;
            3'b100:  ctrl = ALU_XOR;
            3'b101:  ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  ctrl = ALU_OR;
            default: ctrl = ALU_AND;
          endcase
        end
      end
      default: ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_pipe.sv
// ID/EX ALU control register: holds each op in EX for its latency and raises
// busy toward the hazard unit while a multi-cycle op occupies the stage.
module alu_ctrl_pipe
  import alu_pkg::*;
#(
  parameter int unsigned CTRL_W   = CTRL_W_DEF,
  parameter bit          ENABLE_M = 1'b1,
  parameter int unsigned MUL_LAT  = 2,
  parameter int unsigned DIV_LAT  = 33
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [1:0]        alu_op,
  input  logic [2:0]        funct3,
  input  logic              funct7_5,
  input  logic              funct7_0,
  input  logic              is_rtype,
  input  logic              stall_in,
  input  logic              flush,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_alu_ctrl,
  output logic              ex_illegal,
  output logic              ex_last,
  output logic              busy
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  logic [CODE_W-1:0] dec_ctrl;
  logic              dec_illegal;
  logic [CNT_W-1:0]  dec_cnt;
  logic [CNT_W-1:0]  cnt;

  alu_op_decode #(
    .ENABLE_M (ENABLE_M)
  ) u_decode (
    .alu_op   (alu_op),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .funct7_0 (funct7_0),
    .is_rtype (is_rtype),
    .ctrl     (dec_ctrl),
    .illegal  (dec_illegal)
  );

  assign dec_cnt = CNT_W'(op_latency(dec_ctrl, MUL_LAT, DIV_LAT) - 32'd1);
  assign ex_last = ex_valid & (cnt == '0);
  assign busy    = ex_valid & (cnt != '0);

  // Priority: flush, then remaining-latency countdown, then stall hold, then capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_alu_ctrl <= '0;
      ex_illegal  <= 1'b0;
      cnt         <= '0;
    end else if (flush) begin
      ex_valid    <= 1'b0;
      ex_alu_ctrl <= '0;
      ex_illegal  <= 1'b0;
      cnt         <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end else if (!stall_in) begin
      ex_valid    <= id_valid;
      ex_alu_ctrl <= id_valid ? CTRL_W'(dec_ctrl) : '0;
      ex_illegal  <= id_valid & dec_illegal;
      cnt         <= id_valid ? dec_cnt : '0;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Self-checking bench for alu_ctrl_pipe: decode table, multi-cycle corner
// sequences and a randomized run against a cycle-level reference model.
module tb_alu_ctrl_pipe;

  localparam int unsigned MUL_LAT = 2;
  localparam int unsigned DIV_LAT = 33;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [1:0] alu_op;
  logic [2:0] funct3;
  logic       funct7_5, funct7_0, is_rtype, stall_in, flush;

  logic       o0_valid, o0_ill, o0_last, o0_busy;
  logic [4:0] o0_ctrl;
  logic       o1_valid, o1_ill, o1_last, o1_busy;
  logic [4:0] o1_ctrl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_ctrl_pipe #(.CTRL_W(5), .ENABLE_M(1'b1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut_m (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .alu_op(alu_op), .funct3(funct3),
    .funct7_5(funct7_5), .funct7_0(funct7_0), .is_rtype(is_rtype), .stall_in(stall_in),
    .flush(flush), .ex_valid(o0_valid), .ex_alu_ctrl(o0_ctrl), .ex_illegal(o0_ill),
    .ex_last(o0_last), .busy(o0_busy));

  alu_ctrl_pipe #(.CTRL_W(5), .ENABLE_M(1'b0), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut_nom (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .alu_op(alu_op), .funct3(funct3),
    .funct7_5(funct7_5), .funct7_0(funct7_0), .is_rtype(is_rtype), .stall_in(stall_in),
    .flush(flush), .ex_valid(o1_valid), .ex_alu_ctrl(o1_ctrl), .ex_illegal(o1_ill),
    .ex_last(o1_last), .busy(o1_busy));

  // Reference model: an op occupies EX for rem more cycles, counting the current one.
  typedef struct {
    logic       valid;
    logic [4:0] ctrl;
    logic       ill;
    int         rem;
  } model_t;

  model_t m0, m1;

  typedef struct {
    logic [1:0] op;
    logic [2:0] f3;
    logic       f75, f70, rt;
    logic [4:0] c0;
    logic       i0;
    logic [4:0] c1;
    logic       i1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] op, input logic [2:0] f3, input logic f75,
                              input logic f70, input logic rt, input logic [4:0] c0,
                              input logic i0, input logic [4:0] c1, input logic i1);
    vec_t v;
    v.op = op; v.f3 = f3; v.f75 = f75; v.f70 = f70; v.rt = rt;
    v.c0 = c0; v.i0 = i0; v.c1 = c1; v.i1 = i1;
    return v;
  endfunction

  // Returns {illegal, code}.
  function automatic logic [5:0] ref_dec(input logic [1:0] op, input logic [2:0] f3,
                                         input logic f75, input logic f70, input logic rt,
                                         input bit en_m);
    if (op == 2'd0) return 6'd0;
    if (op == 2'd1) return 6'd1;
    if (op == 2'd3) return 6'd10;
    if (rt && f70) return en_m ? {1'b0, 2'b10, f3} : 6'b100000;
    case (f3)
      3'd0:    return (rt && f75) ? 6'd1 : 6'd0;
      3'd1:    return 6'd6;
      3'd2:    return 6'd5;
      3'd3:    return 6'd9;
      3'd4:    return 6'd4;
      3'd5:    return f75 ? 6'd8 : 6'd7;
      3'd6:    return 6'd3;
      default: return 6'd2;
    endcase
  endfunction

  function automatic int ref_lat(input logic [4:0] c);
    if (c >= 5'd16 && c <= 5'd19) return int'(MUL_LAT);
    if (c >= 5'd20 && c <= 5'd23) return int'(DIV_LAT);
    return 1;
  endfunction

  function automatic model_t mstep(input model_t s, input bit en_m);
    model_t     n;
    logic [5:0] d;
    n = s;
    d = ref_dec(alu_op, funct3, funct7_5, funct7_0, is_rtype, en_m);
    if (flush) begin
      n.valid = 1'b0; n.ctrl = 5'd0; n.ill = 1'b0; n.rem = 0;
    end else if (s.valid && s.rem > 1) begin
      n.rem = s.rem - 1;
    end else if (!stall_in) begin
      n.valid = id_valid;
      n.ctrl  = id_valid ? d[4:0] : 5'd0;
      n.ill   = id_valid & d[5];
      n.rem   = id_valid ? ref_lat(d[4:0]) : 0;
    end
    return n;
  endfunction

  function automatic logic [8:0] mexp(input model_t s);
    return {s.valid, s.ctrl, s.ill, s.valid && s.rem == 1, s.valid && s.rem > 1};
  endfunction

  function automatic void mreset();
    m0 = '{valid: 1'b0, ctrl: 5'd0, ill: 1'b0, rem: 0};
    m1 = '{valid: 1'b0, ctrl: 5'd0, ill: 1'b0, rem: 0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    m0 = mstep(m0, 1'b1);
    m1 = mstep(m1, 1'b0);
    #1;
  endtask

  task automatic set_op(input logic v, input logic [1:0] op, input logic [2:0] f3,
                        input logic f75, input logic f70, input logic rt);
    id_valid = v; alu_op = op; funct3 = f3; funct7_5 = f75; funct7_0 = f70; is_rtype = rt;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && o0_busy; k++) step();
    chk("drain_timeout", 32'(o0_busy), 32'd0);
  endtask

  task automatic check_zero(input string name);
    chk(name, 32'({o0_valid, o0_ctrl, o0_ill, o0_last, o0_busy}), 32'd0);
    chk(name, 32'({o1_valid, o1_ctrl, o1_ill, o1_last, o1_busy}), 32'd0);
  endtask

  initial begin
    int busy_cnt, last_cnt;

    vecs.push_back(mk(2'd2, 3'd0, 1'b1, 1'b0, 1'b1, 5'd1,  1'b0, 5'd1,  1'b0)); // sub
    vecs.push_back(mk(2'd2, 3'd0, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0)); // addi
    vecs.push_back(mk(2'd2, 3'd5, 1'b1, 1'b0, 1'b0, 5'd8,  1'b0, 5'd8,  1'b0)); // srai
    vecs.push_back(mk(2'd2, 3'd5, 1'b0, 1'b0, 1'b1, 5'd7,  1'b0, 5'd7,  1'b0)); // srl
    vecs.push_back(mk(2'd2, 3'd1, 1'b0, 1'b0, 1'b1, 5'd6,  1'b0, 5'd6,  1'b0)); // sll
    vecs.push_back(mk(2'd2, 3'd2, 1'b0, 1'b0, 1'b0, 5'd5,  1'b0, 5'd5,  1'b0)); // slti
    vecs.push_back(mk(2'd2, 3'd3, 1'b0, 1'b0, 1'b1, 5'd9,  1'b0, 5'd9,  1'b0)); // sltu
    vecs.push_back(mk(2'd2, 3'd4, 1'b0, 1'b0, 1'b1, 5'd4,  1'b0, 5'd4,  1'b0)); // xor
    vecs.push_back(mk(2'd2, 3'd6, 1'b0, 1'b0, 1'b0, 5'd3,  1'b0, 5'd3,  1'b0)); // ori
    vecs.push_back(mk(2'd2, 3'd7, 1'b1, 1'b0, 1'b1, 5'd2,  1'b0, 5'd2,  1'b0)); // and
    vecs.push_back(mk(2'd1, 3'd7, 1'b1, 1'b1, 1'b1, 5'd1,  1'b0, 5'd1,  1'b0)); // branch
    vecs.push_back(mk(2'd3, 3'd2, 1'b0, 1'b1, 1'b1, 5'd10, 1'b0, 5'd10, 1'b0)); // lui
    vecs.push_back(mk(2'd0, 3'd4, 1'b1, 1'b1, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0)); // ld/st
    vecs.push_back(mk(2'd2, 3'd0, 1'b0, 1'b1, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0)); // I-type f7_0
    vecs.push_back(mk(2'd2, 3'd0, 1'b0, 1'b1, 1'b1, 5'd16, 1'b0, 5'd0,  1'b1)); // mul
    vecs.push_back(mk(2'd2, 3'd3, 1'b0, 1'b1, 1'b1, 5'd19, 1'b0, 5'd0,  1'b1)); // mulhu
    vecs.push_back(mk(2'd2, 3'd4, 1'b0, 1'b1, 1'b1, 5'd20, 1'b0, 5'd0,  1'b1)); // div
    vecs.push_back(mk(2'd2, 3'd7, 1'b0, 1'b1, 1'b1, 5'd23, 1'b0, 5'd0,  1'b1)); // remu

    rst_n = 1'b0; stall_in = 1'b0; flush = 1'b0;
    set_op(1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    mreset();
    #12;
    check_zero("reset_state");
    rst_n = 1'b1;

    // Decode table: each op captured once, then drained.
    foreach (vecs[i]) begin
      set_op(1'b1, vecs[i].op, vecs[i].f3, vecs[i].f75, vecs[i].f70, vecs[i].rt);
      step();
      set_op(1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("vec%0d_ctrl", i), 32'(o0_ctrl), 32'(vecs[i].c0));
      chk($sformatf("vec%0d_ill", i), 32'(o0_ill), 32'(vecs[i].i0));
      chk($sformatf("vec%0d_valid", i), 32'(o0_valid), 32'd1);
      chk($sformatf("vec%0d_last", i), 32'(o0_last), 32'(vecs[i].c0 < 5'd16));
      chk($sformatf("vec%0d_nom", i), 32'({o1_valid, o1_ctrl, o1_ill, o1_last, o1_busy}),
          32'({1'b1, vecs[i].c1, vecs[i].i1, 1'b1, 1'b0}));
      drain();
      step();
    end

    // div with a follow-on add held upstream while busy.
    set_op(1'b1, 2'd2, 3'd4, 1'b0, 1'b1, 1'b1);
    busy_cnt = 0; last_cnt = 0;
    for (int c = 1; c <= 33; c++) begin
      step();
      if (c == 1) set_op(1'b1, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      if (o0_busy) busy_cnt++;
      if (o0_last) last_cnt++;
      if (c == 33) chk("div_final_cycle", 32'({o0_ctrl, o0_last, o0_busy}), 32'({5'd20, 1'b1, 1'b0}));
    end
    chk("div_busy_cycles", 32'(busy_cnt), 32'd32);
    chk("div_last_pulses", 32'(last_cnt), 32'd1);
    step();
    chk("div_followon", 32'({o0_valid, o0_ctrl, o0_last, o0_busy}), 32'({1'b1, 5'd0, 1'b1, 1'b0}));

    // mul under downstream stall: counts out, then holds on ex_last.
    set_op(1'b1, 2'd2, 3'd0, 1'b0, 1'b1, 1'b1);
    step();
    chk("mul_capture", 32'({o0_ctrl, o0_busy}), 32'({5'd16, 1'b1}));
    stall_in = 1'b1;
    set_op(1'b1, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("mul_stall_hold", 32'({o0_valid, o0_ctrl, o0_last, o0_busy}), 32'({1'b1, 5'd16, 1'b1, 1'b0}));
    end
    stall_in = 1'b0;
    step();
    chk("mul_release", 32'({o0_valid, o0_ctrl, o0_last}), 32'({1'b1, 5'd0, 1'b1}));

    // flush in cycle 5 of a div, with a simultaneous valid op dropped.
    set_op(1'b1, 2'd2, 3'd5, 1'b0, 1'b1, 1'b1);
    step();
    set_op(1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int c = 2; c <= 4; c++) step();
    chk("flush_pre", 32'({o0_ctrl, o0_busy}), 32'({5'd21, 1'b1}));
    flush = 1'b1;
    set_op(1'b1, 2'd3, 3'd0, 1'b0, 1'b0, 1'b0);
    step();
    flush = 1'b0;
    set_op(1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    check_zero("flush_kill");

    // Async reset mid-div: outputs drop before the next clock edge.
    set_op(1'b1, 2'd2, 3'd6, 1'b0, 1'b1, 1'b1);
    step();
    set_op(1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    step(); step();
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    #2 rst_n = 1'b1;
    mreset();
    step();
    check_zero("after_reset");

    // Randomized run against the reference model.
    for (int c = 0; c < 800; c++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      alu_op   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd2;
      funct3   = 3'($urandom);
      funct7_5 = 1'($urandom);
      funct7_0 = 1'($urandom);
      is_rtype = 1'($urandom);
      stall_in = ($urandom_range(0, 5) == 0);
      flush    = ($urandom_range(0, 59) == 0);
      step();
      chk("rand_m", 32'({o0_valid, o0_ctrl, o0_ill, o0_last, o0_busy}), 32'(mexp(m0)));
      chk("rand_nom", 32'({o1_valid, o1_ctrl, o1_ill, o1_last, o1_busy}), 32'(mexp(m1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_pipe.md
Name: alu_ctrl_pipe

Overview:
- Parametrised successor to the combinational ALU decoder, registered into the ID/EX boundary.
- Decodes ALUop/funct3/funct7 for RV32I plus an optional RV32M subset into a CTRL_W-bit ALU control word.
- Holds each operation in EX for its latency: 1 cycle for RV32I ops, MUL_LAT for mul*, DIV_LAT for div/rem.
- Drives a busy stall back to the hazard unit while a multi-cycle op occupies EX; supports flush and downstream stall.

Parameters:
- CTRL_W, 5, ALU control width; must be at least 5 (RV32M codes use bit 4).
- ENABLE_M, 1, decode RV32M ops; when 0, M encodings flag illegal.
- MUL_LAT, 2, EX cycles for mul/mulh/mulhsu/mulhu; must be at least 1.
- DIV_LAT, 33, EX cycles for div/divu/rem/remu; must be at least 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage presents a valid instruction.
- alu_op  in  2  00 add (load/store/jalr), 01 sub (branch), 10 R/I decode, 11 pass-B (lui).
- funct3  in  3  instr[14:12].
- funct7_5  in  1  instr[30].
- funct7_0  in  1  instr[25], M-extension select.
- is_rtype  in  1  instr[5] of opcode (R-type=1, OP-IMM=0).
- stall_in  in  1  downstream hold.
- flush  in  1  synchronous kill of the EX entry.
- ex_valid  out  1  EX holds a live op.
- ex_alu_ctrl  out  CTRL_W  registered ALU control.
- ex_illegal  out  1  registered illegal-encoding flag.
- ex_last  out  1  final EX cycle of the current op.
- busy  out  1  stall request to upstream: ex_valid & !ex_last.

Behaviour:
- Control codes: 00000 add, 00001 sub, 00010 and, 00011 or, 00100 xor, 00101 slt, 00110 sll, 00111 srl, 01000 sra, 01001 sltu, 01010 passb.
- RV32M codes: 10000 mul, 10001 mulh, 10010 mulhsu, 10011 mulhu, 10100 div, 10101 divu, 10110 rem, 10111 remu.
- Decode for alu_op=10:
  - is_rtype & funct7_0 & ENABLE_M: code = {2'b10, funct3}.
  - is_rtype & funct7_0 & !ENABLE_M: illegal=1, code=add.
  - Otherwise by funct3: 000 sub if is_rtype&funct7_5, else add; 001 sll; 010 slt; 011 sltu; 100 xor; 101 sra if funct7_5, else srl (applies to both R and I); 110 or; 111 and.
- Decode for other alu_op values: funct fields are ignored and illegal=0.
- Latency selection: LAT = MUL_LAT for codes 100xx, DIV_LAT for 101xx, else 1.
- Down-counter cnt is sized for max(MUL_LAT, DIV_LAT)-1.
- ex_last = ex_valid & (cnt==0).
- Per-edge priority, highest first:
  - 1. flush: ex_valid=0, ctrl=0, illegal=0, cnt=0. Aborts an in-progress multi-cycle op; overrides capture and stall.
  - 2. busy (cnt>0): cnt decrements; ctrl, valid and illegal hold. stall_in does not freeze counting.
  - 3. stall_in with !busy: all registers hold.
  - 4. Otherwise capture: ex_valid=id_valid; ctrl and illegal from decode (0 when !id_valid); cnt=LAT-1 (0 when !id_valid).
- Upstream holds its instruction while busy=1. The op presented during busy is captured on the edge where busy falls and stall_in=0.
- Op with LAT=L captured at edge N: ex_valid is high for cycles N..N+L-1; busy is high N..N+L-2; ex_last is high in N+L-1 only.
- Back-to-back single-cycle ops sustain one capture per cycle; busy never asserts.
- Reset (async assert, sync deassert assumed upstream): ex_valid=0, ex_alu_ctrl=0, ex_illegal=0, cnt=0. Hence busy=0, ex_last=0.
- Reset mid multi-cycle op: the op is dropped with no ex_last pulse.

Decomposition:
- Package alu_pkg holds:
  - CTRL_W default and alu_ctrl_e enum (all codes above).
  - ALUOP_* constants.
  - Function op_latency(ctrl, MUL_LAT, DIV_LAT).
- Sub-module alu_op_decode: purely combinational decode of alu_op, funct3, funct7_5, funct7_0 and is_rtype into ctrl and illegal. It is instantiated once ahead of the pipeline register/counter logic in alu_ctrl_pipe.

Test Plan:
- Reset then id_valid=1, alu_op=10, funct3=000, is_rtype=1, funct7_5=1 -> next cycle ex_alu_ctrl=00001, ex_valid=1, ex_last=1, busy=0. The same encoding with is_rtype=0 -> 00000.
- alu_op=10, funct3=101, funct7_5=1 (srai) -> 01000; funct7_5=0 -> 00111. alu_op=01 with any funct3 -> 00001. alu_op=11 -> 01010.
- div (R-type, funct7_0=1, funct3=100) with DIV_LAT=33 -> ex_alu_ctrl=10100; busy high 32 cycles; ex_last single pulse in cycle 33; the held follow-on add captures the following edge.
- mul with MUL_LAT=2 under stall_in=1 throughout -> busy 1 cycle; then ex_last stays high and registers hold until stall_in drops.
- flush asserted in cycle 5 of a div -> next edge ex_valid=0, busy=0, cnt=0; a simultaneous id_valid is dropped. rst_n pulsed low mid-div -> outputs 0 immediately (asynchronous).
- ENABLE_M=0 with funct7_0=1 and R-type -> ex_illegal=1, ex_alu_ctrl=00000, latency 1.
